mmio_peripherals: RTL and testbench
===================================

// Module: mmio_peripherals
// PURPOSE
// - Memory-mapped I/O slave downstream of the CPU's MEM stage: decodes data-side loads/stores that fall in the
//   MMIO window instead of going to L1D.
// - Owns the board LED register, a synchronised and debounced photoresistor input port, and a free-running timer
//   with a compare register.
// - Drives the board LEDs, which are active-low.
// PARAMETERS
// - BASE_ADDR        32'h0000_8000  base of the 64-byte MMIO window; window = BASE_ADDR..BASE_ADDR+63
// - DEBOUNCE_CYCLES  16             consecutive stable cycles before a photores bit is accepted (>=1)
// - LED_WIDTH        5              number of LEDs driven
// PORTS
// - clock          in   1          CPU clock; all state on posedge
// - reset_n        in   1          asynchronous, active-low reset
// - address        in   32         byte address from the MEM stage
// - write_data     in   32         store data
// - mem_write      in   1          store request
// - mem_read       in   1          load request
// - mem_op_length  in   3          byte/half/word length code, the same encoding the decoder emits
// - hit            out  1          combinational: address is inside the window
// - read_data      out  32         load data; valid while ready=1
// - ready          out  1          one-cycle response strobe
// - photores       in   2          raw asynchronous photoresistor inputs
// - led            out  LED_WIDTH  active-low LED pins
// BEHAVIOUR
// - Reset values: led = all 1s (off), read_data = 0, ready = 0, all registers = 0, FSM = IDLE.
// - Register map (offsets from BASE_ADDR, word-aligned; address[1:0] ignored):
//   - 0x00 LED      RW  [LED_WIDTH-1:0]
//   - 0x04 PHOTO    RO  [1:0] debounced value
//   - 0x08 CHANGE   W1C [1:0] sticky change flags
//   - 0x0C TIMER    RO  32-bit counter
//   - 0x10 CMP      RW  32-bit compare value
//   - 0x14 TSTAT    W1C [0] sticky match flag
// - FSM states: IDLE, RESP.
//   - IDLE: a request (mem_read|mem_write) with hit=1 is captured at posedge; go to RESP.
//   - RESP: ready=1 and read_data valid for exactly one cycle; then back to IDLE.
//   - Latency: request cycle + 1.
//   - New requests arriving while in RESP are ignored; the requester holds its request until it sees ready.
//   - A request that is simultaneously read and write is treated as a write; read_data = 0.
// - Writes commit at the capture edge (IDLE->RESP).
//   - Byte length: updates bits [7:0] only. Half: bits [15:0]. Word: the full register.
//   - Writes to RO or unmapped offsets are dropped.
// - Reads are captured at the same edge. Unmapped offsets read 0; unused register bits read 0.
// - led = ~LED[LED_WIDTH-1:0].
// - Photores path:
//   - Each bit passes a 2-flop synchroniser, then the debouncer.
//   - PHOTO bit updates after the synced value differs from PHOTO for DEBOUNCE_CYCLES consecutive cycles.
//   - The stability counter restarts on any mismatch glitch.
//   - Each PHOTO update sets the matching CHANGE bit.
// - Timer:
//   - +1 every cycle, wraps 32'hFFFF_FFFF -> 0.
//   - TSTAT[0] is set in the cycle TIMER == CMP.
// - Simultaneous set and W1C clear of the same sticky bit: set wins.
// - Reset asserted mid-access aborts the response: ready drops immediately and no register update survives.
// CONFIGURATION
// - Macro MMIO_PHOTORES_DEBOUNCE_EN.
// - Defined: debouncer exactly as above.
// - Undefined: PHOTO = synchroniser output directly (2-cycle latency), CHANGE set on any synced edge,
//   DEBOUNCE_CYCLES unused, no counters synthesised.
// STRUCTURE
// - Shared definitions header holds:
//   - register offset defines (MMIO_LED..MMIO_TSTAT)
//   - MMIO_BASE
//   - MEM_OP length codes, reused from the existing memory-op defines
//   - FSM state encodings
// - Sub-module input_debouncer: one instance per photores bit.
//   - Contains the synchroniser, the stability counter and the macro-controlled bypass.
//   - Outputs value and a one-cycle changed pulse.
// TESTING
// - Reset: hold reset_n=0 -> led=5'b11111, ready=0, TIMER reads 0 shortly after release.
// - LED access: word write 0x15 to BASE+0x00 -> ready exactly 1 cycle later, led=5'b01010; read back returns 32'h15.
// - Sub-word write: byte store 0xAB to CMP holding 32'h1234_5678 -> CMP reads 32'h1234_56AB.
// - Debounce: photores[0] 0->1 for 15 cycles then back to 0 -> PHOTO stays 0.
//   Held 1 for 16+2 cycles -> PHOTO[0]=1, CHANGE=2'b01. W1C 0x1 -> CHANGE=0.
// - Timer match: CMP=40 -> TSTAT[0]=1 from cycle 40. W1C in the exact match cycle -> flag stays 1.
// - Boundaries:
//   - Request to BASE+0x40 -> hit=0, no ready.
//   - Read of unmapped BASE+0x20 -> 0 with ready.
//   - Reset pulse during RESP -> ready=0, LED unchanged from reset value.

Source files
------------

// File: rtl/mmio_peripherals_pkg.sv
// Shared definitions for the MMIO peripheral block.
// Holds:
//   - MMIO_BASE: default base of the 64-byte MMIO window
//   - MMIO_LED..MMIO_TSTAT: register byte offsets inside the window
//   - MEM_OP_*: load/store length codes, matching the memory-op decoder encoding
//   - mmio_state_e: bus response FSM states
//   - merge_store(): applies a byte/half/word store to an existing register value
package mmio_peripherals_pkg;

    localparam logic [31:0] MMIO_BASE   = 32'h0000_8000;

    localparam logic [5:0]  MMIO_LED    = 6'h00;
    localparam logic [5:0]  MMIO_PHOTO  = 6'h04;
    localparam logic [5:0]  MMIO_CHANGE = 6'h08;
    localparam logic [5:0]  MMIO_TIMER  = 6'h0C;
    localparam logic [5:0]  MMIO_CMP    = 6'h10;
    localparam logic [5:0]  MMIO_TSTAT  = 6'h14;

    localparam logic [2:0]  MEM_OP_BYTE = 3'b000;
    localparam logic [2:0]  MEM_OP_HALF = 3'b001;
    localparam logic [2:0]  MEM_OP_WORD = 3'b010;

    typedef enum logic {
        StIdle,
        StResp
    } mmio_state_e;

    // Byte/half stores touch only the low bits; any other code is a full-word store.
    function automatic logic [31:0] merge_store(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [2:0]  len);
        logic [31:0] res;
        case (len)
            MEM_OP_BYTE: res = {old_val[31:8], new_val[7:0]};
            MEM_OP_HALF: res = {old_val[31:16], new_val[15:0]};
            default:     res = new_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mmio_peripherals_input_debouncer.sv
// Synchroniser and debouncer for one asynchronous input bit.
// Configuration macro: MMIO_PHOTORES_DEBOUNCE_EN
//   defined   - value follows the synchronised input only after it has differed from value for
//               DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
//   undefined - value is the synchroniser output; no counter exists.
// Ports:
//   clock    in  CPU clock
//   reset_n  in  asynchronous active-low reset
//   raw      in  asynchronous input bit
//   value    out accepted (debounced) value
//   changed  out one-cycle pulse, high in the cycle before value toggles
module mmio_peripherals_input_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic value,
    output logic changed
);

    logic sync1_q, sync2_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef MMIO_PHOTORES_DEBOUNCE_EN
    localparam int unsigned CntWidth = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                value_q, value_d;

    always_comb begin
        cnt_d   = '0;
        value_d = value_q;
        changed = 1'b0;
        if (sync2_q != value_q) begin
            if (cnt_q == CntWidth'(DEBOUNCE_CYCLES - 1)) begin
                value_d = sync2_q;
                changed = 1'b1;
            end else begin
                cnt_d = cnt_q + CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            value_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            value_q <= value_d;
        end
    end

    assign value = value_q;
`else
    localparam int unsigned unused_cycles = DEBOUNCE_CYCLES;

    // sync2_q takes sync1_q at the next edge, so a difference here flags an imminent edge.
    assign value   = sync2_q;
    assign changed = sync1_q ^ sync2_q;
`endif

endmodule

// File: rtl/mmio_peripherals.sv
// Memory-mapped peripheral slave behind the CPU MEM stage: LED register, debounced photoresistor
// port with sticky change flags, free-running timer with compare and sticky match flag.
// Configuration macro: MMIO_PHOTORES_DEBOUNCE_EN (see mmio_peripherals_input_debouncer).
// Ports:
//   clock, reset_n        CPU clock, asynchronous active-low reset
//   address, write_data   MEM-stage byte address and store data
//   mem_write, mem_read   store / load request (held until ready)
//   mem_op_length         byte/half/word length code (MEM_OP_*)
//   hit                   combinational: address falls inside the 64-byte window
//   read_data, ready      load data and one-cycle response strobe
//   photores              raw asynchronous photoresistor inputs
//   led                   active-low LED pins
module mmio_peripherals
    import mmio_peripherals_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = MMIO_BASE,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned LED_WIDTH       = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [31:0]          address,
    input  logic [31:0]          write_data,
    input  logic                 mem_write,
    input  logic                 mem_read,
    input  logic [2:0]           mem_op_length,
    output logic                 hit,
    output logic [31:0]          read_data,
    output logic                 ready,
    input  logic [1:0]           photores,
    output logic [LED_WIDTH-1:0] led
);

    mmio_state_e          state_q, state_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [31:0]          cmp_q, cmp_d;
    logic [31:0]          timer_q, timer_d;
    logic [1:0]           change_q, change_d;
    logic                 tstat_q, tstat_d;
    logic [31:0]          read_data_q, read_data_d;

    logic [1:0]  photo, photo_changed;
    logic        req, do_wr, do_rd;
    logic [5:0]  reg_off;
    logic [31:0] rd_val, old_val, store_val;
    logic [1:0]  change_clr;
    logic        tstat_clr;
    logic        unused_addr;

    assign unused_addr = ^address[1:0];
    assign hit         = (address[31:6] == BASE_ADDR[31:6]);

    for (genvar i = 0; i < 2; i++) begin : g_photo
        mmio_peripherals_input_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clock  (clock),
            .reset_n(reset_n),
            .raw    (photores[i]),
            .value  (photo[i]),
            .changed(photo_changed[i])
        );
    end

    always_comb begin
        req     = (mem_read | mem_write) & hit & (state_q == StIdle);
        // A combined read+write request is a write and returns 0.
        do_wr   = req & mem_write;
        do_rd   = req & ~mem_write;
        reg_off = {address[5:2], 2'b00};

        rd_val = '0;
        case (reg_off)
            MMIO_LED:    rd_val = 32'(led_q);
            MMIO_PHOTO:  rd_val = {30'b0, photo};
            MMIO_CHANGE: rd_val = {30'b0, change_q};
            MMIO_TIMER:  rd_val = timer_q;
            MMIO_CMP:    rd_val = cmp_q;
            MMIO_TSTAT:  rd_val = {31'b0, tstat_q};
            default:     rd_val = '0;
        endcase

        old_val   = (reg_off == MMIO_CMP) ? cmp_q : 32'(led_q);
        store_val = merge_store(old_val, write_data, mem_op_length);

        led_d = led_q;
        cmp_d = cmp_q;
        if (do_wr && reg_off == MMIO_LED) led_d = store_val[LED_WIDTH-1:0];
        if (do_wr && reg_off == MMIO_CMP) cmp_d = store_val;

        // Sticky flags: a set in the same cycle as a clear wins.
        change_clr = (do_wr && reg_off == MMIO_CHANGE) ? write_data[1:0] : 2'b00;
        change_d   = (change_q & ~change_clr) | photo_changed;
        tstat_clr  = do_wr && (reg_off == MMIO_TSTAT) && write_data[0];
        tstat_d    = (tstat_q & ~tstat_clr) | (timer_q == cmp_q);

        timer_d = timer_q + 32'd1;

        state_d     = state_q;
        read_data_d = read_data_q;
        ready       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d     = StResp;
                    read_data_d = do_rd ? rd_val : 32'd0;
                end
            end
            StResp: begin
                ready   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            led_q       <= '0;
            cmp_q       <= '0;
            timer_q     <= '0;
            change_q    <= '0;
            tstat_q     <= 1'b0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            led_q       <= led_d;
            cmp_q       <= cmp_d;
            timer_q     <= timer_d;
            change_q    <= change_d;
            tstat_q     <= tstat_d;
            read_data_q <= read_data_d;
        end
    end

    assign read_data = read_data_q;
    assign led       = ~led_q;

endmodule

// File: tb/tb_mmio_peripherals.sv
// Scoreboard bench for mmio_peripherals: each bus access pushes its expected read_data, a
// negedge monitor pops and compares whenever ready is high.
module tb_mmio_peripherals;
    import mmio_peripherals_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_8000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [2:0]  mem_op_length = MEM_OP_WORD;
    logic        hit;
    logic [31:0] read_data;
    logic        ready;
    logic [1:0]  photores = 2'b00;
    logic [4:0]  led;

    int checks = 0;
    int errors = 0;
    int edges;

    logic [31:0] exp_data_q[$];
    string       exp_name_q[$];

    always #5 clock = ~clock;

    mmio_peripherals dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .address      (address),
        .write_data   (write_data),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_op_length(mem_op_length),
        .hit          (hit),
        .read_data    (read_data),
        .ready        (ready),
        .photores     (photores),
        .led          (led)
    );

    // Posedges since reset release; at a negedge this equals the DUT timer value.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) edges <= 0;
        else          edges <= edges + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (ready === 1'b1) begin
            if (exp_data_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready=1 with read_data %h expected no response",
                         read_data);
            end else begin
                check(exp_name_q.pop_front(), read_data, exp_data_q.pop_front());
            end
        end
    end

    // Called at a negedge with the FSM idle; returns at a negedge with the FSM idle again.
    task automatic access(input logic wr, input logic rd, input logic [5:0] off,
                          input logic [31:0] wdata, input logic [2:0] len,
                          input logic [31:0] exp, input string name);
        address       = BASE + 32'(off);
        write_data    = wdata;
        mem_write     = wr;
        mem_read      = rd;
        mem_op_length = len;
        exp_data_q.push_back(exp);
        exp_name_q.push_back(name);
        @(posedge clock);
        @(negedge clock);
        check({name, "_ready"}, 32'(ready), 32'd1);
        mem_write = 1'b0;
        mem_read  = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] target;

        repeat (3) @(negedge clock);
        check("rst_led", 32'(led), 32'h1F);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_read_data", read_data, 32'd0);
        reset_n = 1'b1;
        access(1'b0, 1'b1, MMIO_TIMER, 32'd0, MEM_OP_WORD, 32'd0, "timer_after_reset");

        // LED register
        access(1'b1, 1'b0, MMIO_LED, 32'h15, MEM_OP_WORD, 32'd0, "led_wr");
        check("led_pins_15", 32'(led), 32'h0A);
        access(1'b0, 1'b1, MMIO_LED, 32'd0, MEM_OP_WORD, 32'h15, "led_rd");
        access(1'b1, 1'b1, MMIO_LED, 32'hFFFF_FFEA, MEM_OP_WORD, 32'd0, "led_rdwr_is_write");
        check("led_pins_0a", 32'(led), 32'h15);
        access(1'b0, 1'b1, MMIO_LED, 32'd0, MEM_OP_WORD, 32'h0A, "led_unused_bits");
        access(1'b1, 1'b0, MMIO_LED, 32'hF1, MEM_OP_BYTE, 32'd0, "led_byte_wr");
        access(1'b0, 1'b1, MMIO_LED, 32'd0, MEM_OP_WORD, 32'h11, "led_byte_rd");

        // Sub-word stores to CMP
        access(1'b1, 1'b0, MMIO_CMP, 32'h1234_5678, MEM_OP_WORD, 32'd0, "cmp_word_wr");
        access(1'b1, 1'b0, MMIO_CMP, 32'hFFFF_FFAB, MEM_OP_BYTE, 32'd0, "cmp_byte_wr");
        access(1'b0, 1'b1, MMIO_CMP, 32'd0, MEM_OP_WORD, 32'h1234_56AB, "cmp_byte_rd");
        access(1'b1, 1'b0, MMIO_CMP, 32'h5555_BEEF, MEM_OP_HALF, 32'd0, "cmp_half_wr");
        access(1'b0, 1'b1, MMIO_CMP, 32'd0, MEM_OP_WORD, 32'h1234_BEEF, "cmp_half_rd");

        // RO write dropped, unmapped read, running timer
        access(1'b1, 1'b0, MMIO_PHOTO, 32'h3, MEM_OP_WORD, 32'd0, "photo_ro_wr");
        access(1'b0, 1'b1, MMIO_PHOTO, 32'd0, MEM_OP_WORD, 32'd0, "photo_ro_rd");
        access(1'b0, 1'b1, 6'h20, 32'd0, MEM_OP_WORD, 32'd0, "unmapped_rd");
        access(1'b0, 1'b1, MMIO_TIMER, 32'd0, MEM_OP_WORD, 32'(edges), "timer_running");

        // Window boundaries
        address = BASE + 32'h3C;
        #1 check("hit_last_word", 32'(hit), 32'd1);
        address = BASE - 32'd4;
        #1 check("hit_below_base", 32'(hit), 32'd0);
        @(negedge clock);
        address  = BASE + 32'h40;
        mem_read = 1'b1;
        #1 check("hit_past_window", 32'(hit), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("no_ready_outside", 32'(ready), 32'd0);
        end
        mem_read = 1'b0;
        @(negedge clock);

        // Photoresistor: 15-cycle glitch, then a long hold
        photores = 2'b01;
        repeat (15) @(negedge clock);
        photores = 2'b00;
        repeat (5) @(negedge clock);
        access(1'b0, 1'b1, MMIO_PHOTO, 32'd0, MEM_OP_WORD, 32'd0, "photo_after_glitch");
`ifdef MMIO_PHOTORES_DEBOUNCE_EN
        access(1'b0, 1'b1, MMIO_CHANGE, 32'd0, MEM_OP_WORD, 32'd0, "change_after_glitch");
`else
        access(1'b0, 1'b1, MMIO_CHANGE, 32'd0, MEM_OP_WORD, 32'd1, "change_after_glitch");
`endif
        access(1'b1, 1'b0, MMIO_CHANGE, 32'h3, MEM_OP_WORD, 32'd0, "change_clr_glitch");
        photores = 2'b01;
        repeat (20) @(negedge clock);
        access(1'b0, 1'b1, MMIO_PHOTO, 32'd0, MEM_OP_WORD, 32'd1, "photo_after_hold");
        access(1'b0, 1'b1, MMIO_CHANGE, 32'd0, MEM_OP_WORD, 32'd1, "change_after_hold");
        access(1'b1, 1'b0, MMIO_CHANGE, 32'h1, MEM_OP_WORD, 32'd0, "change_w1c");
        access(1'b0, 1'b1, MMIO_CHANGE, 32'd0, MEM_OP_WORD, 32'd0, "change_cleared");

        // Timer compare, with a W1C landing in the exact match cycle
        target = 32'(edges) + 32'd40;
        access(1'b1, 1'b0, MMIO_CMP, target, MEM_OP_WORD, 32'd0, "cmp_target_wr");
        access(1'b1, 1'b0, MMIO_TSTAT, 32'h1, MEM_OP_WORD, 32'd0, "tstat_initial_clr");
        access(1'b0, 1'b1, MMIO_TSTAT, 32'd0, MEM_OP_WORD, 32'd0, "tstat_pre");
        for (int i = 0; i < 100 && 32'(edges) != target - 32'd2; i++) @(negedge clock);
        check("tstat_align", 32'(edges), target - 32'd2);
        access(1'b0, 1'b1, MMIO_TSTAT, 32'd0, MEM_OP_WORD, 32'd0, "tstat_before_match");
        access(1'b1, 1'b0, MMIO_TSTAT, 32'h1, MEM_OP_WORD, 32'd0, "tstat_w1c_at_match");
        access(1'b0, 1'b1, MMIO_TSTAT, 32'd0, MEM_OP_WORD, 32'd1, "tstat_set_wins");
        access(1'b1, 1'b0, MMIO_TSTAT, 32'h1, MEM_OP_WORD, 32'd0, "tstat_w1c_late");
        access(1'b0, 1'b1, MMIO_TSTAT, 32'd0, MEM_OP_WORD, 32'd0, "tstat_cleared");

        // Reset pulse while the response is being presented
        address       = BASE + 32'(MMIO_LED);
        write_data    = 32'h03;
        mem_op_length = MEM_OP_WORD;
        mem_write     = 1'b1;
        @(posedge clock);
        #1 check("resp_before_reset", 32'(ready), 32'd1);
        #1 reset_n = 1'b0;
        #1 check("ready_dropped_by_reset", 32'(ready), 32'd0);
        check("led_after_abort", 32'(led), 32'h1F);
        mem_write = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        access(1'b0, 1'b1, MMIO_LED, 32'd0, MEM_OP_WORD, 32'd0, "led_reg_after_abort");
        check("led_pins_after_abort", 32'(led), 32'h1F);

        repeat (3) @(negedge clock);
        check("scoreboard_drained", 32'(exp_data_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
